// File: rtl/dmem_result_responder.sv
// Data-port responder for the single-cycle RISC-V core.
// Holds a word-addressed data RAM and a read-only MMIO window with the cycle
// count, store count and status. A completion monitor watches the store stream
// and settles on PASS, FAIL or TMO so that any build can tell how a program ended.
module dmem_result_responder #(
    parameter int unsigned DEPTH        = 64,      // RAM depth in 32-bit words, power of two
    parameter logic [31:0] SIG_ADDR     = 32'd100, // byte address of the terminating signature store
    parameter logic [31:0] SIG_VALUE    = 32'd7,   // signature value that means PASS
    parameter logic [31:0] SCRATCH_ADDR = 32'd96,  // other store address allowed in strict mode
    parameter bit          STRICT       = 1'b1,    // 1: any other store address is a failure
    parameter int unsigned TIMEOUT      = 40       // RUN cycles allowed before TMO
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] result,
    output logic [31:0] cycles
);

    localparam int unsigned ADDR_BITS    = $clog2(DEPTH);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TMO
    } monitorState_t;

    monitorState_t         state;
    monitorState_t         nextState;
    logic [31:0]           resultNext;
    logic [31:0]           storeCount;
    logic [31:0]           mem [DEPTH];

    logic [ADDR_BITS-1:0]  wordIdx;
    logic                  inRam;
    logic                  inMmio;
    logic                  aligned;
    logic                  sigHit;
    logic                  illegalStore;
    logic                  ramWrite;

    // Address decode shared by the read mux, the RAM write port and the monitor.
    assign wordIdx  = DataAdr[ADDR_BITS+1:2];
    assign inRam    = (DataAdr[31:ADDR_BITS+2] == '0);
    assign inMmio   = DataAdr[31];
    assign aligned  = (DataAdr[1:0] == 2'b00);
    assign sigHit   = (DataAdr == SIG_ADDR);
    assign ramWrite = MemWrite && aligned && inRam;

    // A store that ends the program with FAIL unless it is the signature store itself.
    assign illegalStore = !aligned
                       || (!inRam && !inMmio)
                       || (STRICT && !sigHit && (DataAdr != SCRATCH_ADDR));

    // Status flags are a pure decode of the registered monitor state.
    assign done    = (state != ST_RUN);
    assign pass    = (state == ST_PASS);
    assign fail    = (state == ST_FAIL) || (state == ST_TMO);
    assign timeout = (state == ST_TMO);

    // Data RAM write port: aligned in-range stores land in any monitor state.
    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // block RAM and survives a mid-program reset; its contents start as X.
    always_ff @(posedge clk) begin
        if (ramWrite) begin
            mem[wordIdx] <= WriteData;
        end
    end

    // Combinational load path: RAM word, MMIO register or zero.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case can leave it unassigned and infer a latch.
    always_comb begin
        ReadData = '0;
        if (inRam) begin
            ReadData = mem[wordIdx];
        end else if (inMmio) begin
            case (DataAdr[3:2])
                2'd0:    ReadData = cycles;
                2'd1:    ReadData = storeCount;
                2'd2:    ReadData = {28'b0, timeout, fail, pass, done};
                default: ReadData = '0;
            endcase
        end
    end

    // Monitor next state: a terminating store beats a same-cycle timeout.
    always_comb begin
        nextState  = state;
        resultNext = result;
        if (state == ST_RUN) begin
            if (MemWrite && sigHit) begin
                nextState  = (WriteData == SIG_VALUE) ? ST_PASS : ST_FAIL;
                resultNext = WriteData;
            end else if (MemWrite && illegalStore) begin
                nextState  = ST_FAIL;
                resultNext = WriteData;
            end else if (cycles == TIMEOUT_LAST) begin
                nextState  = ST_TMO;
                resultNext = '0;
            end
        end
    end

    // Monitor state, result and the two saturating counters.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            result     <= '0;
            cycles     <= '0;
            storeCount <= '0;
        end else begin
            state  <= nextState;
            result <= resultNext;
            if ((state == ST_RUN) && (cycles != '1)) begin
                cycles <= cycles + 32'd1;
            end
            if (MemWrite && (storeCount != '1)) begin
                storeCount <= storeCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_result_responder.sv
// Directed bench for dmem_result_responder: a strict instance and a permissive
// instance share one stimulus stream; expected values are hand-computed.
module tb_dmem_result_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;

    logic [31:0] ReadData, result, cycles;
    logic        done, pass, fail, timeout;

    logic [31:0] looseReadData, looseResult, looseCycles;
    logic        looseDone, loosePass, looseFail, looseTimeout;

    int checks = 0;
    int errors = 0;

    dmem_result_responder #(.STRICT(1'b1)) dut (
        .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
        .MemWrite(MemWrite), .ReadData(ReadData), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .result(result), .cycles(cycles)
    );

    dmem_result_responder #(.STRICT(1'b0)) dutLoose (
        .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
        .MemWrite(MemWrite), .ReadData(looseReadData), .done(looseDone),
        .pass(loosePass), .fail(looseFail), .timeout(looseTimeout),
        .result(looseResult), .cycles(looseCycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive a store at the current negedge; it is sampled on the next posedge.
    task automatic doStore(input logic [31:0] adr, input logic [31:0] data);
        DataAdr   = adr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic loadChk(input string tag, input logic [31:0] adr, input logic [31:0] expected);
        DataAdr  = adr;
        MemWrite = 1'b0;
        #1;
        check(tag, ReadData, expected);
    endtask

    // Pulse reset across one negedge; returns at the negedge where it is released.
    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        MemWrite = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // Reset values while reset is held.
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_cycles", cycles, 32'd0);
        loadChk("rst_storecount", 32'h8000_0004, 32'd0);
        #9 reset = 1'b0;                      // released at 22 ns
        @(negedge clk);                       // 30 ns; posedge at 25 already counted

        // Scratch store then signature store -> PASS; edges 25, 35, 45 counted.
        doStore(32'd96, 32'd3);
        doStore(32'd100, 32'd7);
        check("pass_pass", 32'(pass), 32'd1);
        check("pass_done", 32'(done), 32'd1);
        check("pass_fail", 32'(fail), 32'd0);
        check("pass_result", result, 32'd7);
        check("pass_cycles", cycles, 32'd3);
        loadChk("pass_ram24", 32'd96, 32'd3);
        loadChk("pass_ram25", 32'd100, 32'd7);
        loadChk("pass_storecount", 32'h8000_0004, 32'd2);
        repeat (3) @(negedge clk);
        check("pass_cycles_frozen", cycles, 32'd3);
        loadChk("mmio_cycles", 32'h8000_0000, 32'd3);
        loadChk("mmio_status_pass", 32'h8000_0008, 32'h3);
        loadChk("mmio_sub3", 32'h8000_000C, 32'd0);
        loadChk("oor_read", 32'h0000_0400, 32'd0);

        // A later store is ignored by the monitor but still counts and writes RAM.
        doStore(32'd100, 32'd5);
        check("sticky_pass", 32'(pass), 32'd1);
        check("sticky_pass_result", result, 32'd7);
        loadChk("sticky_storecount", 32'h8000_0004, 32'd3);
        loadChk("sticky_ram25", 32'd100, 32'd5);

        // Asynchronous reset out of PASS, away from any clock edge.
        reset = 1'b1;
        #1;
        check("async_pass", 32'(pass), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_result", result, 32'd0);
        check("async_cycles", cycles, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Mid-run reset after a scratch store: RAM survives, program reruns to PASS.
        doStore(32'd96, 32'd3);
        check("midrun_cycles", cycles, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrun_rst_cycles", cycles, 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        loadChk("midrun_rst_storecount", 32'h8000_0004, 32'd0);
        loadChk("midrun_ram_kept", 32'd96, 32'd3);
        @(negedge clk);
        reset = 1'b0;
        doStore(32'd100, 32'd7);
        check("midrun_pass", 32'(pass), 32'd1);
        check("midrun_result", result, 32'd7);

        // Wrong signature -> FAIL, sticky against a later correct signature.
        doReset();
        doStore(32'd100, 32'd5);
        check("badsig_fail", 32'(fail), 32'd1);
        check("badsig_pass", 32'(pass), 32'd0);
        check("badsig_result", result, 32'd5);
        loadChk("badsig_status", 32'h8000_0008, 32'h5);
        doStore(32'd100, 32'd7);
        check("badsig_sticky_fail", 32'(fail), 32'd1);
        check("badsig_sticky_pass", 32'(pass), 32'd0);
        check("badsig_sticky_result", result, 32'd5);
        loadChk("badsig_ram25", 32'd100, 32'd7);
        loadChk("badsig_storecount", 32'h8000_0004, 32'd2);

        // Ordinary RAM store: FAIL when strict, plain RAM write when permissive.
        doReset();
        doStore(32'd80, 32'd9);
        check("strict_fail", 32'(fail), 32'd1);
        check("strict_result", result, 32'd9);
        check("loose_done", 32'(looseDone), 32'd0);
        check("loose_fail", 32'(looseFail), 32'd0);
        check("loose_pass", 32'(loosePass), 32'd0);
        check("loose_timeout", 32'(looseTimeout), 32'd0);
        check("loose_result", looseResult, 32'd0);
        check("loose_cycles", looseCycles, 32'd1);
        DataAdr = 32'd80;
        #1;
        check("loose_ram20", looseReadData, 32'd9);

        // Timeout with no stores: still RUN after 39 edges, TMO at edge 40.
        doReset();
        repeat (39) @(negedge clk);
        check("tmo_pre_cycles", cycles, 32'd39);
        check("tmo_pre_done", 32'(done), 32'd0);
        check("tmo_pre_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        check("tmo_timeout", 32'(timeout), 32'd1);
        check("tmo_fail", 32'(fail), 32'd1);
        check("tmo_done", 32'(done), 32'd1);
        check("tmo_pass", 32'(pass), 32'd0);
        check("tmo_result", result, 32'd0);
        check("tmo_cycles", cycles, 32'd40);
        repeat (3) @(negedge clk);
        check("tmo_cycles_frozen", cycles, 32'd40);
        // timeout|fail|done = 4'b1101
        loadChk("tmo_status", 32'h8000_0008, 32'hD);

        // Signature store on the timeout edge wins over the timeout.
        doReset();
        repeat (39) @(negedge clk);
        doStore(32'd100, 32'd7);
        check("race_pass", 32'(pass), 32'd1);
        check("race_timeout", 32'(timeout), 32'd0);
        check("race_result", result, 32'd7);
        check("race_cycles", cycles, 32'd40);

        // A legal scratch store on the timeout edge does not stop the timeout.
        doReset();
        repeat (39) @(negedge clk);
        doStore(32'd96, 32'h11);
        check("scratch_race_timeout", 32'(timeout), 32'd1);
        check("scratch_race_result", result, 32'd0);

        // Misaligned out-of-range store.
        doReset();
        doStore(32'h0000_0102, 32'd1);
        check("mis_oor_fail", 32'(fail), 32'd1);
        check("mis_oor_result", result, 32'd1);
        loadChk("mis_oor_storecount", 32'h8000_0004, 32'd1);

        // Misaligned store inside the RAM region must not touch RAM.
        doReset();
        doStore(32'd96, 32'hA5);
        check("mis_ram_run", 32'(done), 32'd0);
        doStore(32'd98, 32'h5A);
        check("mis_ram_fail", 32'(fail), 32'd1);
        check("mis_ram_result", result, 32'h5A);
        loadChk("mis_ram_word", 32'd96, 32'hA5);
        loadChk("mis_ram_lowbits", 32'd98, 32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
